hrange_arbiter: RTL and testbench

Sequencer and arbiter that shares one `hrange` generator instance between two caller modules. Each caller issues a start pulse with its own `base`, `limit` and `step`. The arbiter queues the request and grants the generator round-robin. It launches the generator with the winner's captured arguments, then routes the generator's ready/valid output stream and completion back to that caller only. It sits between two generated function modules and a single `hrange` core.

---
 rtl/hrange_arbiter.sv | 106 ++++++++++
 tb/tb_hrange_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hrange_arbiter.sv
// hrange_arbiter: round-robin sharing of one hrange generator between two callers
module hrange_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic                    c0_start,
  input  logic signed [WIDTH-1:0] c0_base,
  input  logic signed [WIDTH-1:0] c0_limit,
  input  logic signed [WIDTH-1:0] c0_step,
  input  logic                    c0_ready,
  output logic                    c0_valid,
  output logic signed [WIDTH-1:0] c0_0,
  output logic                    c0_done,
  output logic                    c0_pending,
  input  logic                    c1_start,
  input  logic signed [WIDTH-1:0] c1_base,
  input  logic signed [WIDTH-1:0] c1_limit,
  input  logic signed [WIDTH-1:0] c1_step,
  input  logic                    c1_ready,
  output logic                    c1_valid,
  output logic signed [WIDTH-1:0] c1_0,
  output logic                    c1_done,
  output logic                    c1_pending,
  output logic                    g_reset,
  output logic                    g_start,
  output logic signed [WIDTH-1:0] g_base,
  output logic signed [WIDTH-1:0] g_limit,
  output logic signed [WIDTH-1:0] g_step,
  output logic                    g_ready,
  input  logic                    g_valid,
  input  logic signed [WIDTH-1:0] g_0,
  input  logic                    g_done
);
  typedef enum logic [1:0] {INIT, IDLE, LAUNCH, RUN} state_t;
  state_t                 state;
  logic                   owner, last, grant, run;
  logic [1:0]             pend;
  logic [1:0][WIDTH-1:0]  base_q, limit_q, step_q;
  // with both requests waiting, the client that did not win last time goes next
  assign grant = &pend ? !last : pend[1];
  assign run = state == RUN;
  // the owner sees the generator stream directly; nothing is buffered
  assign c0_valid = run && !owner && g_valid;
  assign c1_valid = run && owner && g_valid;
  assign c0_0 = c0_valid ? g_0 : '0;
  assign c1_0 = c1_valid ? g_0 : '0;
  assign g_ready = run && (owner ? c1_ready : c0_ready);
  assign g_base = base_q[owner];
  assign g_limit = limit_q[owner];
  assign g_step = step_q[owner];
  assign c0_pending = pend[0];
  assign c1_pending = pend[1];
  // sequencer: reset pulse, grant, launch, run until the generator reports done
  always_ff @(posedge _clock or negedge _reset)
    if (!_reset) begin
      state <= INIT;
      owner <= 1'b0;
      last <= 1'b1;
      pend <= '0;
      g_reset <= 1'b0;
      g_start <= 1'b0;
      c0_done <= 1'b0;
      c1_done <= 1'b0;
      base_q <= '0;
      limit_q <= '0;
      step_q <= '0;
    end else begin
      g_start <= 1'b0;
      c0_done <= 1'b0;
      c1_done <= 1'b0;
      case (state)
        INIT: begin
          g_reset <= !g_reset;
          if (g_reset) state <= IDLE;
        end
        IDLE: if (|pend) begin
          owner <= grant;
          last <= grant;
          g_start <= 1'b1;
          state <= LAUNCH;
        end
        LAUNCH: begin
          pend[owner] <= 1'b0;
          state <= RUN;
        end
        RUN: if (g_done && !g_valid) begin
          c0_done <= !owner;
          c1_done <= owner;
          state <= IDLE;
        end
      endcase
      if (c0_start) begin
        pend[0] <= 1'b1;
        base_q[0] <= c0_base;
        limit_q[0] <= c0_limit;
        step_q[0] <= c0_step;
      end
      if (c1_start) begin
        pend[1] <= 1'b1;
        base_q[1] <= c1_base;
        limit_q[1] <= c1_limit;
        step_q[1] <= c1_step;
      end
    end
endmodule

// File: tb/tb_hrange_arbiter.sv
// tb_hrange_arbiter: directed table, hand sequences and randomized scoreboard for hrange_arbiter
module tb_hrange_arbiter;
  localparam int W = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] c_start = '0, c_ready = '0;
  logic signed [W-1:0] c_base [2], c_limit [2], c_step [2];
  logic c0_valid, c0_done, c0_pending, c1_valid, c1_done, c1_pending;
  logic signed [W-1:0] c0_0, c1_0, g_base, g_limit, g_step, g_0;
  logic g_reset, g_start, g_ready, g_valid;
  logic g_done = 1'b0;
  hrange_arbiter #(.WIDTH(W)) dut (
    ._clock(clk), ._reset(rst_n),
    .c0_start(c_start[0]), .c0_base(c_base[0]), .c0_limit(c_limit[0]), .c0_step(c_step[0]),
    .c0_ready(c_ready[0]), .c0_valid(c0_valid), .c0_0(c0_0), .c0_done(c0_done), .c0_pending(c0_pending),
    .c1_start(c_start[1]), .c1_base(c_base[1]), .c1_limit(c_limit[1]), .c1_step(c_step[1]),
    .c1_ready(c_ready[1]), .c1_valid(c1_valid), .c1_0(c1_0), .c1_done(c1_done), .c1_pending(c1_pending),
    .g_reset(g_reset), .g_start(g_start), .g_base(g_base), .g_limit(g_limit), .g_step(g_step),
    .g_ready(g_ready), .g_valid(g_valid), .g_0(g_0), .g_done(g_done)
  );
  // behavioural hrange core: emits base, base+step, ... while short of limit, then a done pulse
  logic signed [W-1:0] gc = '0, gl = '0, gs = '0;
  logic gact = 1'b0, more;
  assign more = gs > 0 ? gc < gl : gc > gl;
  assign g_valid = gact && more;
  assign g_0 = gc;
  always @(posedge clk) begin
    g_done <= 1'b0;
    if (g_reset) gact <= 1'b0;
    else if (g_start) begin
      gc <= g_base;
      gl <= g_limit;
      gs <= g_step;
      gact <= 1'b1;
    end else if (gact && !more) begin
      gact <= 1'b0;
      g_done <= 1'b1;
    end else if (g_valid && g_ready) gc <= gc + gs;
  end
  // monitor: records transfers and pulses between clock edges
  int rx0[$], rx1[$], exp0[$], exp1[$], done_order[$];
  int done_cnt[2] = '{0, 0};
  int greset_cnt = 0, gstart_cnt = 0, ready_err = 0;
  always @(negedge clk) begin
    if (c0_valid && c_ready[0]) rx0.push_back(int'(c0_0));
    if (c1_valid && c_ready[1]) rx1.push_back(int'(c1_0));
    if (c0_done) begin done_cnt[0]++; done_order.push_back(0); end
    if (c1_done) begin done_cnt[1]++; done_order.push_back(1); end
    if (g_reset) greset_cnt++;
    if (g_start) gstart_cnt++;
    if ((c0_valid && g_ready != c_ready[0]) || (c1_valid && g_ready != c_ready[1]) || (c0_valid && c1_valid)) ready_err++;
  end
  int n_cmp = 0, n_fail = 0;
  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic int rxn(input int k);
    return k != 0 ? rx1.size() : rx0.size();
  endfunction
  function automatic int rxv(input int k, input int i);
    if (i >= rxn(k)) return -999999;
    return k != 0 ? rx1[i] : rx0[i];
  endfunction
  function automatic logic any_out();
    return |{c0_valid, c0_0, c0_done, c0_pending, c1_valid, c1_0, c1_done, c1_pending,
             g_reset, g_start, g_base, g_limit, g_step, g_ready};
  endfunction
  task automatic clear_rx;
    rx0.delete();
    rx1.delete();
    done_order.delete();
  endtask
  task automatic start1(input int k, input int b, input int l, input int s);
    c_start[k] = 1'b1;
    c_base[k] = b;
    c_limit[k] = l;
    c_step[k] = s;
    tick;
    c_start[k] = 1'b0;
  endtask
  task automatic wait_done(input int k, input int prev);
    for (int t = 0; t < 300; t++) begin
      if (done_cnt[k] > prev) break;
      tick;
    end
    chk("done_seen", longint'(done_cnt[k] > prev), 1);
  endtask
  task automatic chk_range(input string nm, input int k, input int first, input int n, input int step);
    chk({nm, "_len"}, rxn(k), n);
    for (int i = 0; i < n; i++) chk(nm, rxv(k, i), first + i * step);
  endtask
  typedef struct packed {int k; int b; int l; int s; int n;} vec_t;
  vec_t tbl[6];
  int etb[6][6];
  task automatic run_vec(input int idx);
    vec_t v;
    int d, o, gs0;
    v = tbl[idx];
    clear_rx();
    d = done_cnt[v.k];
    o = done_cnt[1 - v.k];
    gs0 = gstart_cnt;
    c_ready = 2'b11;
    start1(v.k, v.b, v.l, v.s);
    wait_done(v.k, d);
    tick;
    chk("vec_len", rxn(v.k), v.n);
    for (int i = 0; i < v.n; i++) chk("vec_val", rxv(v.k, i), etb[idx][i]);
    chk("vec_other_rx", rxn(1 - v.k), 0);
    chk("vec_other_done", done_cnt[1 - v.k], o);
    chk("vec_done_once", done_cnt[v.k], d + 1);
    chk("vec_gstart_once", gstart_cnt - gs0, 1);
  endtask
  task automatic sim_pair(input int first);
    int d0, d1;
    clear_rx();
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    c_ready = 2'b11;
    c_base[0] = 0; c_limit[0] = 4; c_step[0] = 1;
    c_base[1] = 10; c_limit[1] = 13; c_step[1] = 1;
    c_start = 2'b11;
    tick;
    c_start = 2'b00;
    for (int t = 0; t < 300; t++) begin
      if (done_cnt[0] > d0 && done_cnt[1] > d1) break;
      tick;
    end
    chk("sim_done_count", done_order.size(), 2);
    chk("sim_first", done_order.size() > 0 ? done_order[0] : -1, first);
    chk_range("sim_c0", 0, 0, 4, 1);
    chk_range("sim_c1", 1, 10, 3, 1);
  endtask
  initial begin
    int gr0, d0, d1, ns0, ns1, pend_low, e0, found, b, l, s;
    for (int k = 0; k < 2; k++) begin c_base[k] = 0; c_limit[k] = 0; c_step[k] = 0; end
    tbl[0] = '{0, 0, 10, 2, 5};      etb[0] = '{0, 2, 4, 6, 8, 0};
    tbl[1] = '{1, 10, 13, 1, 3};     etb[1] = '{10, 11, 12, 0, 0, 0};
    tbl[2] = '{0, 5, -1, -2, 3};     etb[2] = '{5, 3, 1, 0, 0, 0};
    tbl[3] = '{1, 3, 3, 1, 0};       etb[3] = '{0, 0, 0, 0, 0, 0};
    tbl[4] = '{0, -3, 0, 1, 3};      etb[4] = '{-3, -2, -1, 0, 0, 0};
    tbl[5] = '{1, -100, -50, 25, 2}; etb[5] = '{-100, -75, 0, 0, 0, 0};
    // reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      tick;
      c_start = 2'($urandom);
      c_ready = 2'($urandom);
      for (int k = 0; k < 2; k++) begin c_base[k] = $urandom; c_limit[k] = $urandom; c_step[k] = $urandom; end
      @(negedge clk);
      chk("reset_outputs_zero", any_out(), 0);
    end
    tick;
    c_start = 2'b00;
    c_ready = 2'b11;
    gr0 = greset_cnt;
    rst_n = 1'b1;
    repeat (5) tick;
    chk("init_greset_once", greset_cnt - gr0, 1);
    chk("init_no_gstart", gstart_cnt, 0);
    chk("init_no_pending", {c1_pending, c0_pending}, 0);
    // grant latency
    clear_rx();
    d0 = done_cnt[0];
    start1(0, 1, 3, 1);
    chk("lat_pend_n1", c0_pending, 1);
    chk("lat_gstart_n1", g_start, 0);
    tick;
    chk("lat_gstart_n2", g_start, 1);
    chk("lat_gbase_n2", g_base, 1);
    chk("lat_glimit_n2", g_limit, 3);
    tick;
    chk("lat_pend_n3", c0_pending, 0);
    chk("lat_gstart_n3", g_start, 0);
    wait_done(0, d0);
    chk_range("lat_vals", 0, 1, 2, 1);
    // table of single-client runs
    for (int i = 0; i < 6; i++) run_vec(i);
    // simultaneous starts: last grant was c1, so c0 first twice; after a c0 run, c1 first
    sim_pair(0);
    sim_pair(0);
    run_vec(0);
    sim_pair(1);
    // backpressure
    clear_rx();
    e0 = ready_err;
    d0 = done_cnt[0];
    c_ready = 2'b11;
    start1(0, 0, 6, 1);
    for (int t = 0; t < 300 && done_cnt[0] == d0; t++) begin
      c_ready[0] = ~c_ready[0];
      tick;
    end
    c_ready = 2'b11;
    chk("bp_ready_mirror", ready_err - e0, 0);
    chk_range("bp_vals", 0, 0, 6, 1);
    // queued request with arguments changed after capture
    clear_rx();
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    start1(0, 0, 10, 2);
    repeat (3) tick;
    start1(1, 5, 8, 1);
    c_base[1] = 99;
    pend_low = 0;
    for (int t = 0; t < 300; t++) begin
      if (done_cnt[0] > d0) break;
      if (!c1_pending) pend_low++;
      tick;
    end
    chk("q_pending_held", pend_low, 0);
    chk("q_c1_waits", rx1.size(), 0);
    wait_done(1, d1);
    chk_range("q_c0", 0, 0, 5, 2);
    chk_range("q_c1", 1, 5, 3, 1);
    // reset in the middle of a run with c1 queued
    clear_rx();
    start1(0, 0, 10, 2);
    start1(1, 7, 9, 1);
    found = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (c0_valid && c0_0 == 4) begin found = 1; break; end
    end
    chk("rm_reached_4", found, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_outputs_zero", any_out(), 0);
    repeat (2) @(posedge clk);
    #1;
    clear_rx();
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    gr0 = greset_cnt;
    rst_n = 1'b1;
    repeat (5) tick;
    chk("rm_greset_once", greset_cnt - gr0, 1);
    chk("rm_pending_cleared", {c1_pending, c0_pending}, 0);
    start1(1, 0, 3, 1);
    wait_done(1, d1);
    chk_range("rm_c1", 1, 0, 3, 1);
    chk("rm_no_c0_out", rx0.size(), 0);
    chk("rm_no_c0_done", done_cnt[0], d0);
    // randomized traffic against a per-client expected-value scoreboard
    clear_rx();
    exp0.delete();
    exp1.delete();
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    ns0 = 0;
    ns1 = 0;
    e0 = ready_err;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        c_ready[k] = $urandom_range(3) != 0;
        if (!(k != 0 ? c1_pending : c0_pending) && $urandom_range(9) == 0) begin
          b = int'($urandom_range(20)) - 10;
          s = int'($urandom_range(2)) + 1;
          if ($urandom_range(1) == 1) s = -s;
          l = $urandom_range(3) == 0 ? b - s : b + s * int'($urandom_range(8));
          c_start[k] = 1'b1;
          c_base[k] = b; c_limit[k] = l; c_step[k] = s;
          for (int v = b; s > 0 ? v < l : v > l; v += s)
            if (k != 0) exp1.push_back(v); else exp0.push_back(v);
          if (k != 0) ns1++; else ns0++;
        end else begin
          c_start[k] = 1'b0;
          c_base[k] = $urandom; c_limit[k] = $urandom; c_step[k] = $urandom;
        end
      end
      tick;
    end
    c_start = 2'b00;
    c_ready = 2'b11;
    for (int t = 0; t < 3000; t++) begin
      if (done_cnt[0] - d0 == ns0 && done_cnt[1] - d1 == ns1) break;
      tick;
    end
    repeat (3) tick;
    chk("rand_done0", done_cnt[0] - d0, ns0);
    chk("rand_done1", done_cnt[1] - d1, ns1);
    chk("rand_len0", rx0.size(), exp0.size());
    chk("rand_len1", rx1.size(), exp1.size());
    for (int i = 0; i < exp0.size(); i++) chk("rand_val0", rxv(0, i), exp0[i]);
    for (int i = 0; i < exp1.size(); i++) chk("rand_val1", rxv(1, i), exp1[i]);
    chk("rand_ready_path", ready_err - e0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
